lcd_instruction_executor: RTL

//   Responder side of the LCD instruction handshake. Accepts one 10-bit {RS,RW,DATA[7:0]}

---
 rtl/lcd_pkg.sv | 22 ++
 rtl/lcd_wait_timer.sv | 19 +
 rtl/lcd_instruction_executor.sv | 97 +++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// lcd_pkg: shared LCD state encoding, instruction field indices and default timing constants.
package lcd_pkg;
   typedef enum logic [3:0] {
      IDLE, UP_SETUP, UP_EN, UP_HOLD, GAP, LO_SETUP, LO_EN, LO_HOLD, EXEC_WAIT
   } state_t;
   localparam int RS_BIT      = 9;
   localparam int RW_BIT      = 8;
   localparam int DATA_MSB    = 7;
   localparam int TIMER_W     = 17;
   localparam int T_SETUP_DEF = 2;
   localparam int T_EN_DEF    = 12;
   localparam int T_HOLD_DEF  = 1;
   localparam int T_GAP_DEF   = 50;
   localparam int T_EXEC_DEF  = 2000;
   localparam int T_CLEAR_DEF = 82000;
   function automatic state_t next_state(input state_t s);
      return (s == EXEC_WAIT) ? IDLE : state_t'(s + 4'd1);
   endfunction
   function automatic logic upper_phase(input state_t s);
      return (s == UP_SETUP) || (s == UP_EN) || (s == UP_HOLD);
   endfunction
endpackage

// File: rtl/lcd_wait_timer.sv
// lcd_wait_timer: loadable down-counter that stops at zero.
module lcd_wait_timer #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_value,
   output logic [W-1:0] value,
   output logic         zero
);
   logic [W-1:0] value_q, value_d;
   always_comb value_d = load ? load_value : (value_q != '0) ? value_q - W'(1) : value_q;
   always_ff @(posedge clk or posedge reset)
      if (reset) value_q <= '0;
      else value_q <= value_d;
   assign value = value_q;
   assign zero  = (value_q == '0);
endmodule

// File: rtl/lcd_instruction_executor.sv
// lcd_instruction_executor: drives one 10-bit instruction onto the 4-bit LCD bus as two E strobes.
// Define LCD_CLEAR_WAIT_EN to give clear/return-home the long T_CLEAR execution wait.
module lcd_instruction_executor
   import lcd_pkg::*;
#(
   parameter int T_SETUP = T_SETUP_DEF,
   parameter int T_EN    = T_EN_DEF,
   parameter int T_HOLD  = T_HOLD_DEF,
   parameter int T_GAP   = T_GAP_DEF,
   parameter int T_EXEC  = T_EXEC_DEF
`ifdef LCD_CLEAR_WAIT_EN
   ,
   parameter int T_CLEAR = T_CLEAR_DEF
`endif
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] instruction,
   input  logic       instruction_valid,
   output logic       instruction_done,
   output logic       busy,
   output logic       lcd_e,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic [3:0] lcd_db
);
   localparam logic [TIMER_W-1:0] TL_SETUP = TIMER_W'(T_SETUP - 1);
   localparam logic [TIMER_W-1:0] TL_EN    = TIMER_W'(T_EN - 1);
   localparam logic [TIMER_W-1:0] TL_HOLD  = TIMER_W'(T_HOLD - 1);
   localparam logic [TIMER_W-1:0] TL_GAP   = TIMER_W'(T_GAP - 1);
   state_t               state_q, state_d;
   logic                 rs_q, rs_d;
   logic [DATA_MSB:0]    data_q, data_d;
   logic                 done_q, done_d, busy_q, busy_d, e_q, e_d, lcd_rs_q, lcd_rs_d;
   logic [3:0]           db_q, db_d;
   logic                 accept, tmr_load, tmr_zero;
   logic [TIMER_W-1:0]   tmr_load_val, exec_load, tmr_value_unused;
   logic                 unused_rw;
   assign unused_rw = instruction[RW_BIT];
`ifdef LCD_CLEAR_WAIT_EN
   assign exec_load = (!rs_q && data_q[7:2] == 6'd0) ? TIMER_W'(T_CLEAR - 1) : TIMER_W'(T_EXEC - 1);
`else
   assign exec_load = TIMER_W'(T_EXEC - 1);
`endif
   lcd_wait_timer #(.W(TIMER_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (tmr_load),
      .load_value (tmr_load_val),
      .value      (tmr_value_unused),
      .zero       (tmr_zero)
   );
   // Outputs are computed from the next state so they register alongside it.
   always_comb begin
      accept       = (state_q == IDLE) && instruction_valid;
      state_d      = accept ? UP_SETUP : (state_q != IDLE && tmr_zero) ? next_state(state_q) : state_q;
      rs_d         = accept ? instruction[RS_BIT] : rs_q;
      data_d       = accept ? instruction[DATA_MSB:0] : data_q;
      tmr_load     = (state_d != state_q);
      tmr_load_val = (state_d == UP_SETUP || state_d == LO_SETUP) ? TL_SETUP :
                     (state_d == UP_EN || state_d == LO_EN) ? TL_EN :
                     (state_d == UP_HOLD || state_d == LO_HOLD) ? TL_HOLD :
                     (state_d == GAP) ? TL_GAP :
                     (state_d == EXEC_WAIT) ? exec_load : '0;
      done_d       = (state_q == EXEC_WAIT) && (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      e_d          = (state_d == UP_EN) || (state_d == LO_EN);
      lcd_rs_d     = busy_d && rs_d;
      db_d         = !busy_d ? 4'd0 : upper_phase(state_d) ? data_d[7:4] : data_d[3:0];
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q  <= IDLE;
         rs_q     <= 1'b0;
         data_q   <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
         e_q      <= 1'b0;
         lcd_rs_q <= 1'b0;
         db_q     <= '0;
      end else begin
         state_q  <= state_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
         e_q      <= e_d;
         lcd_rs_q <= lcd_rs_d;
         db_q     <= db_d;
      end
   assign instruction_done = done_q;
   assign busy             = busy_q;
   assign lcd_e            = e_q;
   assign lcd_rs           = lcd_rs_q;
   assign lcd_rw           = 1'b0;
   assign lcd_db           = db_q;
endmodule
